// File: rtl/sdram_bus_scheduler_pkg.sv
// Shared width defaults and FSM state encoding for the SDRAM bus scheduler.
package sdram_bus_scheduler_pkg;

    localparam int unsigned DEF_ARBITER_BUS_SIZE = 3;
    localparam int unsigned DEF_PADD_SIZE        = 24;
    localparam int unsigned DEF_CMD_SIZE         = 3;
    localparam int unsigned DEF_DATA_SIZE        = 32;
    localparam int unsigned DEF_FIFO_SIZE        = 8;
    localparam int unsigned DEF_BURST_MAX        = 8;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_OWN     = 2'd1,
        ST_RELEASE = 2'd2
    } state_t;

endpackage

// File: rtl/sdram_bus_scheduler_rr_pick.sv
// Round-robin winner search: first requester above last_owner, wrapping modulo N.
module rr_pick #(
    parameter int unsigned N  = 3,
    parameter int unsigned LW = 2
) (
    input  logic [N-1:0]  request,
    input  logic [LW-1:0] last_owner,
    output logic [N-1:0]  winner
);

    int unsigned pos;
    logic        found;

    always_comb begin
        winner = '0;
        found  = 1'b0;
        pos    = 0;
        for (int unsigned i = 1; i <= N; i++) begin
            pos = 32'(last_owner) + i;
            if (pos >= N) pos = pos - N;
            if (!found && request[LW'(pos)]) begin
                winner[LW'(pos)] = 1'b1;
                found            = 1'b1;
            end
        end
    end

endmodule

// File: rtl/sdram_bus_scheduler.sv
// Three-requester SDRAM bus scheduler: round-robin grant, bounded bursts, one-cycle release gap.
module sdram_bus_scheduler
    import sdram_bus_scheduler_pkg::*;
#(
    parameter int unsigned ARBITER_BUS_SIZE = DEF_ARBITER_BUS_SIZE,
    parameter int unsigned PADD_SIZE        = DEF_PADD_SIZE,
    parameter int unsigned CMD_SIZE         = DEF_CMD_SIZE,
    parameter int unsigned DATA_SIZE        = DEF_DATA_SIZE,
    parameter int unsigned FIFO_SIZE        = DEF_FIFO_SIZE,
    parameter int unsigned BURST_MAX        = DEF_BURST_MAX
) (
    input  logic                        clk0,
    input  logic                        reset,
    input  logic [ARBITER_BUS_SIZE-1:0] bus_request,
    input  logic [PADD_SIZE-1:0]        dma_addr,
    input  logic [PADD_SIZE-1:0]        dcache_addr,
    input  logic [PADD_SIZE-1:0]        icache_addr,
    input  logic [CMD_SIZE-1:0]         dma_cmd,
    input  logic [CMD_SIZE-1:0]         dcache_cmd,
    input  logic [CMD_SIZE-1:0]         icache_cmd,
    input  logic [FIFO_SIZE-1:0]        dma_dataout,
    input  logic [DATA_SIZE-1:0]        dcache_dataout,
    input  logic [DATA_SIZE-1:0]        icache_dataout,
    input  logic [DATA_SIZE-1:0]        sdram_dataout,
    input  logic                        sdram_ack,
    output logic [ARBITER_BUS_SIZE-1:0] bus_grant,
    output logic [PADD_SIZE-1:0]        sdram_addr,
    output logic [CMD_SIZE-1:0]         sdram_cmd,
    output logic [DATA_SIZE-1:0]        sdram_datain,
    output logic [FIFO_SIZE-1:0]        dma_datain,
    output logic [DATA_SIZE-1:0]        dcache_datain,
    output logic [DATA_SIZE-1:0]        icache_datain,
    output logic                        busy
);

    localparam int unsigned LW = $clog2(ARBITER_BUS_SIZE);
    localparam int unsigned CW = $clog2(BURST_MAX + 1);

    state_t                      state;
    logic [LW-1:0]               last_owner;
    logic [LW-1:0]               owner_idx;
    logic [CW-1:0]               cnt;
    logic [ARBITER_BUS_SIZE-1:0] pick;
    logic                        owner_drop;
    logic                        burst_done;

    rr_pick #(
        .N  (ARBITER_BUS_SIZE),
        .LW (LW)
    ) u_rr_pick (
        .request    (bus_request),
        .last_owner (last_owner),
        .winner     (pick)
    );

    assign owner_idx  = bus_grant[2] ? LW'(2) : (bus_grant[1] ? LW'(1) : LW'(0));
    assign owner_drop = ~|(bus_request & bus_grant);
    assign burst_done = sdram_ack && (cnt == CW'(BURST_MAX - 1));

    // Drop and final ack in the same cycle fold into one transition, so one release.
    always_ff @(posedge clk0 or negedge reset) begin
        if (!reset) begin
            state      <= ST_IDLE;
            bus_grant  <= '0;
            cnt        <= '0;
            last_owner <= LW'(ARBITER_BUS_SIZE - 1);
            busy       <= 1'b0;
        end else begin
            case (state)
                ST_IDLE, ST_RELEASE: begin
                    if (|bus_request) begin
                        state     <= ST_OWN;
                        bus_grant <= pick;
                        cnt       <= '0;
                        busy      <= 1'b1;
                    end else begin
                        state     <= ST_IDLE;
                        bus_grant <= '0;
                        busy      <= 1'b0;
                    end
                end
                ST_OWN: begin
                    if (sdram_ack) cnt <= cnt + CW'(1);
                    if (owner_drop || burst_done) begin
                        state      <= ST_RELEASE;
                        bus_grant  <= '0;
                        busy       <= 1'b0;
                        last_owner <= owner_idx;
                    end
                end
                default: begin
                    state     <= ST_IDLE;
                    bus_grant <= '0;
                    busy      <= 1'b0;
                end
            endcase
        end
    end

    // Owner-steered muxes; grant is zero outside OWN so everything idles to zero.
    always_comb begin
        sdram_addr    = '0;
        sdram_cmd     = '0;
        sdram_datain  = '0;
        dma_datain    = '0;
        dcache_datain = '0;
        icache_datain = '0;
        if (bus_grant[0]) begin
            sdram_addr   = dma_addr;
            sdram_cmd    = dma_cmd;
            sdram_datain = DATA_SIZE'(dma_dataout);
            dma_datain   = sdram_dataout[FIFO_SIZE-1:0];
        end else if (bus_grant[1]) begin
            sdram_addr    = dcache_addr;
            sdram_cmd     = dcache_cmd;
            sdram_datain  = dcache_dataout;
            dcache_datain = sdram_dataout;
        end else if (bus_grant[2]) begin
            sdram_addr    = icache_addr;
            sdram_cmd     = icache_cmd;
            sdram_datain  = icache_dataout;
            icache_datain = sdram_dataout;
        end
    end

endmodule

// File: tb/tb_sdram_bus_scheduler.sv
// Directed bench for sdram_bus_scheduler: round-robin order, burst limit, release, reset, data steering.
module tb_sdram_bus_scheduler;

    logic        clk0;
    logic        reset;
    logic [2:0]  bus_request;
    logic [23:0] dma_addr, dcache_addr, icache_addr;
    logic [2:0]  dma_cmd, dcache_cmd, icache_cmd;
    logic [7:0]  dma_dataout;
    logic [31:0] dcache_dataout, icache_dataout, sdram_dataout;
    logic        sdram_ack;
    logic [2:0]  bus_grant;
    logic [23:0] sdram_addr;
    logic [2:0]  sdram_cmd;
    logic [31:0] sdram_datain;
    logic [7:0]  dma_datain;
    logic [31:0] dcache_datain, icache_datain;
    logic        busy;

    int n_cmp = 0;
    int n_err = 0;

    sdram_bus_scheduler dut (
        .clk0           (clk0),
        .reset          (reset),
        .bus_request    (bus_request),
        .dma_addr       (dma_addr),
        .dcache_addr    (dcache_addr),
        .icache_addr    (icache_addr),
        .dma_cmd        (dma_cmd),
        .dcache_cmd     (dcache_cmd),
        .icache_cmd     (icache_cmd),
        .dma_dataout    (dma_dataout),
        .dcache_dataout (dcache_dataout),
        .icache_dataout (icache_dataout),
        .sdram_dataout  (sdram_dataout),
        .sdram_ack      (sdram_ack),
        .bus_grant      (bus_grant),
        .sdram_addr     (sdram_addr),
        .sdram_cmd      (sdram_cmd),
        .sdram_datain   (sdram_datain),
        .dma_datain     (dma_datain),
        .dcache_datain  (dcache_datain),
        .icache_datain  (icache_datain),
        .busy           (busy)
    );

    initial begin
        clk0 = 1'b0;
        forever #5 clk0 = ~clk0;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk0);
        #1;
    endtask

    task automatic do_reset();
        reset       = 1'b0;
        bus_request = 3'b000;
        sdram_ack   = 1'b0;
        repeat (2) tick();
        reset = 1'b1;
    endtask

    logic [2:0]  exp_g [4] = '{3'b001, 3'b010, 3'b100, 3'b001};
    logic [23:0] exp_a [4] = '{24'h111111, 24'h222222, 24'h333333, 24'h111111};

    initial begin
        reset          = 1'b0;
        bus_request    = 3'b000;
        sdram_ack      = 1'b0;
        dma_addr       = 24'h111111;
        dcache_addr    = 24'h222222;
        icache_addr    = 24'h333333;
        dma_cmd        = 3'b010;
        dcache_cmd     = 3'b101;
        icache_cmd     = 3'b011;
        dma_dataout    = 8'hC3;
        dcache_dataout = 32'hDC00_0001;
        icache_dataout = 32'h1C00_0002;
        sdram_dataout  = 32'h0;

        // Reset state and round-robin with all three requesting, ack held high
        bus_request = 3'b111;
        sdram_ack   = 1'b1;
        repeat (2) tick();
        check_eq("rst_grant", 32'(bus_grant), 32'h0);
        check_eq("rst_busy", 32'(busy), 32'h0);
        check_eq("rst_addr", 32'(sdram_addr), 32'h0);
        check_eq("rst_cmd", 32'(sdram_cmd), 32'h0);
        reset = 1'b1;
        for (int k = 0; k < 4; k++) begin
            tick();
            check_eq($sformatf("rr_grant%0d", k), 32'(bus_grant), 32'(exp_g[k]));
            check_eq($sformatf("rr_addr%0d", k), 32'(sdram_addr), 32'(exp_a[k]));
            check_eq($sformatf("rr_busy%0d", k), 32'(busy), 32'h1);
            repeat (7) tick();
            check_eq($sformatf("rr_hold%0d", k), 32'(bus_grant), 32'(exp_g[k]));
            tick();
            check_eq($sformatf("rr_gap%0d", k), 32'(bus_grant), 32'h0);
            check_eq($sformatf("rr_gapbusy%0d", k), 32'(busy), 32'h0);
        end

        // DMA alone: release after the 8th ack, re-grant after one dead cycle
        do_reset();
        bus_request = 3'b001;
        tick();
        check_eq("dma_grant", 32'(bus_grant), 32'h1);
        check_eq("dma_datain_zext", sdram_datain, 32'h0000_00C3);
        check_eq("dma_cmd", 32'(sdram_cmd), 32'h2);
        sdram_ack = 1'b1;
        repeat (7) tick();
        check_eq("dma_ack7_hold", 32'(bus_grant), 32'h1);
        tick();
        check_eq("dma_release", 32'(bus_grant), 32'h0);
        check_eq("dma_release_data", sdram_datain, 32'h0);
        tick();
        check_eq("dma_regrant", 32'(bus_grant), 32'h1);
        sdram_ack   = 1'b0;
        bus_request = 3'b000;
        tick();
        tick();
        check_eq("dma_idle", 32'(bus_grant), 32'h0);

        // dcache owner drops request on cycle 3, no acks
        do_reset();
        bus_request   = 3'b010;
        sdram_dataout = 32'h1234_5678;
        tick();
        check_eq("dc_grant", 32'(bus_grant), 32'h2);
        check_eq("dc_cmd", 32'(sdram_cmd), 32'h5);
        check_eq("dc_rdata", dcache_datain, 32'h1234_5678);
        check_eq("dc_icache_zero", icache_datain, 32'h0);
        tick();
        tick();
        bus_request = 3'b000;
        tick();
        check_eq("dc_release_grant", 32'(bus_grant), 32'h0);
        check_eq("dc_release_cmd", 32'(sdram_cmd), 32'h0);
        check_eq("dc_release_busy", 32'(busy), 32'h0);
        tick();
        check_eq("dc_idle", 32'(bus_grant), 32'h0);

        // Owner drop coincident with the 8th ack gives a single release cycle
        do_reset();
        bus_request = 3'b001;
        tick();
        check_eq("co_grant", 32'(bus_grant), 32'h1);
        sdram_ack = 1'b1;
        repeat (7) tick();
        bus_request = 3'b000;
        tick();
        check_eq("co_release", 32'(bus_grant), 32'h0);
        sdram_ack   = 1'b0;
        bus_request = 3'b010;
        tick();
        check_eq("co_single_release", 32'(bus_grant), 32'h2);
        bus_request = 3'b000;
        tick();
        tick();

        // Reset on beat 4 drops grant at once; icache gets first grant afterwards
        do_reset();
        bus_request = 3'b001;
        tick();
        sdram_ack = 1'b1;
        repeat (3) tick();
        check_eq("mid_owned", 32'(bus_grant), 32'h1);
        reset = 1'b0;
        #1;
        check_eq("mid_rst_grant", 32'(bus_grant), 32'h0);
        check_eq("mid_rst_addr", 32'(sdram_addr), 32'h0);
        check_eq("mid_rst_busy", 32'(busy), 32'h0);
        sdram_ack   = 1'b0;
        bus_request = 3'b100;
        repeat (2) tick();
        check_eq("mid_rst_hold", 32'(bus_grant), 32'h0);
        reset = 1'b1;
        tick();
        check_eq("post_rst_grant", 32'(bus_grant), 32'h4);
        check_eq("post_rst_addr", 32'(sdram_addr), 32'h333333);

        // icache owner receives read data; other requesters see zero
        sdram_dataout = 32'hA5A5_0F0F;
        #1;
        check_eq("ic_rdata", icache_datain, 32'hA5A5_0F0F);
        check_eq("ic_dcache_zero", dcache_datain, 32'h0);
        check_eq("ic_dma_zero", 32'(dma_datain), 32'h0);
        check_eq("ic_wdata", sdram_datain, 32'h1C00_0002);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/sdram_bus_scheduler.md
SDRAM_BUS_SCHEDULER -- requirements
Module: sdram_bus_scheduler

Interface
REQ-001 Parameters SHALL be, one per line: name, default, meaning.
- ARBITER_BUS_SIZE, 3, number of requesters (bit0 DMA, bit1 dcache, bit2 icache).
- PADD_SIZE, 24, SDRAM address width.
- CMD_SIZE, 3, SDRAM command width.
- DATA_SIZE, 32, cache/SDRAM data width.
- FIFO_SIZE, 8, DMA data width.
- BURST_MAX, 8, maximum accepted beats per tenure.

REQ-002 Ports SHALL be, one per line: name, direction, width, meaning.
- clk0  in  1  the only clock; rising edge.
- reset  in  1  reset, asynchronous, active-low.
- bus_request  in  3  per-requester level request.
- dma_addr / dcache_addr / icache_addr  in  PADD_SIZE  requester address.
- dma_cmd / dcache_cmd / icache_cmd  in  CMD_SIZE  requester command.
- dma_dataout  in  FIFO_SIZE  DMA write data.
- dcache_dataout / icache_dataout  in  DATA_SIZE  cache write data.
- sdram_dataout  in  DATA_SIZE  SDRAM read data.
- sdram_ack  in  1  SDRAM accepted one beat this cycle.
- bus_grant  out  3  registered one-hot grant.
- sdram_addr  out  PADD_SIZE  owner address.
- sdram_cmd  out  CMD_SIZE  owner command.
- sdram_datain  out  DATA_SIZE  owner write data.
- dma_datain  out  FIFO_SIZE  read data to DMA.
- dcache_datain / icache_datain  out  DATA_SIZE  read data to caches.
- busy  out  1  high while in OWN.

Function
REQ-003 The FSM SHALL have exactly three states: IDLE, OWN, RELEASE.
REQ-004 Arbitration SHALL be round-robin, searching upward from last_owner+1 modulo 3; last_owner SHALL reset to 2 so that DMA wins first.
REQ-005 In IDLE with bus_request != 0, the next edge SHALL load the winner into bus_grant and enter OWN (grant latency 1 cycle); with no request the FSM SHALL stay in IDLE.
REQ-006 In OWN, a beat counter SHALL increment on each sdram_ack; ack outside OWN SHALL be ignored.
REQ-007 OWN SHALL exit to RELEASE when the owner deasserts its request, or when the ack that makes count == BURST_MAX arrives; if both happen in the same cycle, a single release SHALL occur.
REQ-008 RELEASE SHALL last exactly one cycle with bus_grant = 0. It then enters OWN for the next round-robin winner if any request is pending, else IDLE. last_owner SHALL update on entry to RELEASE.
REQ-009 A requester re-requesting immediately after release SHALL be granted again only if no other requester is pending.
REQ-010 sdram_addr, sdram_cmd and sdram_datain SHALL be combinational muxes of the owner's inputs in OWN and all-zero otherwise; dma_dataout SHALL be zero-extended.
REQ-011 The owner's datain SHALL equal sdram_dataout (DMA receives [FIFO_SIZE-1:0]); non-owners SHALL receive zero.
REQ-012 bus_grant SHALL always be one-hot or zero; the beat counter SHALL clear on every entry to OWN and SHALL never exceed BURST_MAX.

Reset
REQ-013 While reset = 0, the block SHALL hold state = IDLE, bus_grant = 0, counter = 0, last_owner = 2, busy = 0 and all data/address/command outputs = 0.
REQ-014 Reset asserted mid-burst SHALL drop the grant immediately (asynchronously), with no RELEASE cycle; the first grant after deassertion SHALL follow REQ-005.

Structure
REQ-015 Width constants (ARBITER_BUS_SIZE, PADD_SIZE, CMD_SIZE, DATA_SIZE, FIFO_SIZE) and state encodings SHALL live in the shared parameter include.
REQ-016 The round-robin winner search SHALL be one combinational sub-module, rr_pick (inputs: request, last_owner; output: one-hot winner).

Verification
REQ-017 The bench SHALL cover the following directed scenarios:
- After reset, bus_request = 3'b111 held -> grants in order 001, 010, 100, 001, each grant separated by one zero-grant cycle.
- DMA alone, 8 acks -> RELEASE after the 8th ack, then re-grant 001 after one dead cycle.
- dcache owner drops its request on cycle 3 with no acks -> release; sdram_cmd = 0 in RELEASE.
- Owner drop coincident with the 8th ack -> exactly one RELEASE cycle.
- Reset pulled low on beat 4 -> bus_grant = 0 and sdram_addr = 0 in the same cycle; after reset, request 3'b100 -> grant 100 after 1 cycle.
- icache owner, sdram_dataout = 32'hA5A5_0F0F -> icache_datain = 32'hA5A5_0F0F, dcache_datain = 0, dma_datain = 0.
